// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame parser: header byte, FSM state codes,
// default sizing and a length-range helper.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hAA;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LEN     = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] CHK     = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;

  localparam int unsigned DEF_MAX_LEN        = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 8680;

  function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
    return (len != '0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Simple dual-port byte RAM: one synchronous write port, one registered read port.
module uart_frame_buf #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; the array contents are left as-is.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles HDR/LEN/payload/CHK frames from UART bytes and holds a verified
// frame until acknowledged. Optional inter-byte timeout: UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN        = DEF_MAX_LEN,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              frame_valid,
  output logic [7:0]        frame_len,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              crc_err,
  output logic              len_err,
  output logic              ovf_err,
  output logic              timeout_err
);

  if (MAX_LEN < 1 || MAX_LEN > 255 || (2**ADDR_W) < MAX_LEN) begin : g_bad_len
    $error("uart_frame_parser: MAX_LEN must be 1..255 and fit in 2**ADDR_W");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("uart_frame_parser: TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0] state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] idx_q, idx_d;
  logic       frame_valid_q, frame_valid_d;
  logic [7:0] frame_len_q, frame_len_d;
  logic       crc_err_q, crc_err_d;
  logic       len_err_q, len_err_d;
  logic       ovf_err_q, ovf_err_d;
  logic       timeout_err_q, timeout_err_d;
  logic       buf_we;
  logic       tmo_hit;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             in_frame;

  assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);

  // Any rx_done clears the count, so a byte in the expiry cycle wins.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit   = 1'b0;
    if (in_frame && !rx_done) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) tmo_hit   = 1'b1;
      else                                         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    sum_d         = sum_q;
    idx_d         = idx_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    crc_err_d     = 1'b0;
    len_err_d     = 1'b0;
    ovf_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    buf_we        = 1'b0;
    case (state_q)
      IDLE: if (rx_done && rx_data == FRAME_HDR) state_d = LEN;
      LEN: if (rx_done) begin
        if (len_ok(rx_data, MAX_LEN)) begin
          len_d   = rx_data;
          sum_d   = rx_data;
          idx_d   = '0;
          state_d = PAYLOAD;
        end else begin
          len_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      PAYLOAD: if (rx_done) begin
        buf_we = 1'b1;
        sum_d  = sum_q + rx_data;
        idx_d  = idx_q + 8'd1;
        if (idx_q + 8'd1 == len_q) state_d = CHK;
      end
      CHK: if (rx_done) begin
        if (rx_data == sum_q) begin
          frame_len_d   = len_q;
          frame_valid_d = 1'b1;
          state_d       = HOLD;
        end else begin
          crc_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          state_d       = (rx_done && rx_data == FRAME_HDR) ? LEN : IDLE;
        end else if (rx_done) begin
          ovf_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // tmo_hit is only raised in LEN/PAYLOAD/CHK without rx_done, so no other pulse coincides.
    if (tmo_hit) begin
      state_d       = IDLE;
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      ovf_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      idx_q         <= idx_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      crc_err_q     <= crc_err_d;
      len_err_q     <= len_err_d;
      ovf_err_q     <= ovf_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  uart_frame_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk   (Clk),
    .rst   (Rst),
    .we    (buf_we),
    .waddr (idx_q[ADDR_W-1:0]),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;
  assign crc_err     = crc_err_q;
  assign len_err     = len_err_q;
  assign ovf_err     = ovf_err_q;
  assign timeout_err = timeout_err_q;

endmodule
